// File: rtl/mont_pwm_ctrl.sv
// Montgomery-reduction sequencer: streams N coefficient pairs out of synchronous-read memory,
// multiplies and Montgomery-reduces each product, and writes the signed result back in index order.
module mont_pwm_ctrl #(
    parameter int Q    = 8380417,
    parameter int QINV = 58728449,
    parameter int N    = 256,
    parameter int AW   = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic [31:0]   const_i,
    input  logic [AW-1:0] src_a_base_i,
    input  logic [AW-1:0] src_b_base_i,
    input  logic [AW-1:0] dst_base_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_a_o,
    output logic [AW-1:0] rd_addr_b_o,
    input  logic [31:0]   rdata_a_i,
    input  logic [31:0]   rdata_b_i,
    output logic          we_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [31:0]   wdata_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [31:0]        QINV_W = 32'(QINV);
    localparam logic signed [63:0] Q_W    = 64'(Q);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          mode_q;
    logic [31:0]   const_q;
    logic [AW-1:0] base_a_q;
    logic [AW-1:0] base_b_q;
    logic [AW-1:0] base_d_q;
    logic          accept;
    logic          last_rd;

    logic               rd_vld;
    logic               prod_vld;
    logic signed [63:0] prod;
    logic signed [63:0] op_a;
    logic signed [63:0] op_b;
    logic [31:0]        t;
    logic signed [63:0] t_ext;
    logic signed [63:0] diff;

    assign accept  = (state == IDLE) && start_i;
    assign last_rd = (rd_idx == IW'(N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN ends once the last product has left stage 2; its write lands in the final DRAIN cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (last_rd) state_next = DRAIN;
            DRAIN:   if (!rd_vld && !prod_vld) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state)
            RUN: begin
                rd_en_o = 1'b1;
                busy_o  = 1'b1;
            end
            DRAIN:   busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign rd_addr_a_o = base_a_q + AW'(rd_idx);
    assign rd_addr_b_o = base_b_q + AW'(rd_idx);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q   <= 1'b0;
            const_q  <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_d_q <= '0;
            rd_idx   <= '0;
        end else if (accept) begin
            mode_q   <= mode_i;
            const_q  <= const_i;
            base_a_q <= src_a_base_i;
            base_b_q <= src_b_base_i;
            base_d_q <= dst_base_i;
            rd_idx   <= '0;
        end else if (state == RUN) begin
            rd_idx <= rd_idx + IW'(1);
        end
    end

    // p - t*Q is an exact multiple of 2^32, so the upper word is the reduced value.
    always_comb begin
        op_a  = {{32{rdata_a_i[31]}}, rdata_a_i};
        op_b  = mode_q ? {{32{const_q[31]}}, const_q} : {{32{rdata_b_i[31]}}, rdata_b_i};
        t     = prod[31:0] * QINV_W;
        t_ext = {{32{t[31]}}, t};
        diff  = prod - t_ext * Q_W;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_vld    <= 1'b0;
            prod_vld  <= 1'b0;
            prod      <= '0;
            we_o      <= 1'b0;
            wr_addr_o <= '0;
            wdata_o   <= '0;
            wr_idx    <= '0;
        end else begin
            rd_vld   <= (state == RUN);
            prod_vld <= rd_vld;
            we_o     <= prod_vld;
            if (rd_vld) begin
                prod <= op_a * op_b;
            end
            if (accept) begin
                wr_idx <= '0;
            end else if (prod_vld) begin
                wdata_o   <= 32'(diff >>> 32);
                wr_addr_o <= base_d_q + AW'(wr_idx);
                wr_idx    <= wr_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mont_pwm_ctrl.sv
// Bench for mont_pwm_ctrl: random operands over a shared memory model, results compared against
// an arithmetic Montgomery reference, plus a small AW=8/N=4 instance for address wrap.
module tb_mont_pwm_ctrl;

    localparam int Q   = 8380417;
    localparam int N   = 256;
    localparam int AW  = 10;
    localparam int SN  = 4;
    localparam int SAW = 8;

    logic clk = 1'b0;
    logic clk_en = 1'b1;
    logic rst;

    logic          start, mode, rd_en, we, busy, done;
    logic [31:0]   cval, rda, rdb, wd;
    logic [AW-1:0] ba, bb, bd, ra, rb, wa;

    logic           s_start, s_mode, s_rd_en, s_we, s_busy, s_done;
    logic [31:0]    s_cval, s_rda, s_rdb, s_wd;
    logic [SAW-1:0] s_ba, s_bb, s_bd, s_ra, s_rb, s_wa;

    logic [31:0] mem  [0:(1<<AW)-1];
    logic [31:0] smem [0:(1<<SAW)-1];

    int ncyc = 0;
    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0]  w_addr_q[$];
    logic [31:0]    w_data_q[$];
    int             w_cyc_q[$];
    int             done_q[$];
    logic [SAW-1:0] s_addr_q[$];
    logic [31:0]    s_data_q[$];
    int             s_cyc_q[$];
    int             s_done_q[$];
    logic [31:0]    exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 if (clk_en) clk = ~clk;

    mont_pwm_ctrl #(.N(N), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .const_i(cval),
        .src_a_base_i(ba), .src_b_base_i(bb), .dst_base_i(bd),
        .rd_en_o(rd_en), .rd_addr_a_o(ra), .rd_addr_b_o(rb),
        .rdata_a_i(rda), .rdata_b_i(rdb),
        .we_o(we), .wr_addr_o(wa), .wdata_o(wd), .busy_o(busy), .done_o(done)
    );

    mont_pwm_ctrl #(.N(SN), .AW(SAW)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .mode_i(s_mode), .const_i(s_cval),
        .src_a_base_i(s_ba), .src_b_base_i(s_bb), .dst_base_i(s_bd),
        .rd_en_o(s_rd_en), .rd_addr_a_o(s_ra), .rd_addr_b_o(s_rb),
        .rdata_a_i(s_rda), .rdata_b_i(s_rdb),
        .we_o(s_we), .wr_addr_o(s_wa), .wdata_o(s_wd), .busy_o(s_busy), .done_o(s_done)
    );

    // synchronous-read memories with a write port
    always @(posedge clk) begin
        if (rd_en) begin
            rda <= mem[ra];
            rdb <= mem[rb];
        end
        if (we) mem[wa] <= wd;
        if (s_rd_en) begin
            s_rda <= smem[s_ra];
            s_rdb <= smem[s_rb];
        end
        if (s_we) smem[s_wa] <= s_wd;
    end

    // monitor: cycle numbers relative to the start sample are ncyc - s
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (we) begin
            w_addr_q.push_back(wa);
            w_data_q.push_back(wd);
            w_cyc_q.push_back(ncyc);
        end
        if (done) done_q.push_back(ncyc);
        if (s_we) begin
            s_addr_q.push_back(s_wa);
            s_data_q.push_back(s_wd);
            s_cyc_q.push_back(ncyc);
        end
        if (s_done) s_done_q.push_back(ncyc);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] mont_ref(input logic [31:0] a, input logic [31:0] b);
        longint p, t, r;
        p = longint'($signed(a)) * longint'($signed(b));
        t = longint'(int'(p * longint'(58728449)));
        r = (p - t * longint'(Q)) / 64'sd4294967296;
        return r[31:0];
    endfunction

    function automatic logic [31:0] rand_coef();
        int v;
        v = int'($urandom_range(2 * Q - 2)) - (Q - 1);
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic clear_mon();
        w_addr_q.delete(); w_data_q.delete(); w_cyc_q.delete(); done_q.delete();
    endtask

    task automatic build_exp(input logic m, input logic [31:0] c, input logic [AW-1:0] a, b);
        logic [AW-1:0] ai, bi;
        for (int i = 0; i < N; i++) begin
            ai = a + AW'(i);
            bi = b + AW'(i);
            exp_q.push_back(mont_ref(mem[ai], m ? c : mem[bi]));
        end
    endtask

    task automatic start_big(input logic m, input logic [31:0] c, input logic [AW-1:0] a, b, d,
                             output int s);
        @(negedge clk);
        start = 1'b1; mode = m; cval = c; ba = a; bb = b; bd = d;
        s = ncyc;
        @(negedge clk);
        start = 1'b0; mode = ~m; cval = $urandom;
        ba = AW'($urandom); bb = AW'($urandom); bd = AW'($urandom);
    endtask

    task automatic wait_big(input int want, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done_q.size() >= want) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_timeout: done_o count %0d, required %0d within %0d cycles",
                     done_q.size(), want, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int s;
        for (int i = 0; i < 512; i++) mem[i] = rand_coef();
        clear_mon();
        start_big(1'b0, 32'd0, 10'd0, 10'd256, 10'd512, s);
        repeat (4) @(negedge clk);
        vectors++;
        if ({busy, rd_en, we} !== 3'b111) begin
            miscompares++;
            $display("FAIL run_active: busy/rd_en/we=%b required 111", {busy, rd_en, we});
        end
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, we, rd_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: busy/done/we/rd_en=%b required 0000", {busy, done, we, rd_en});
        end
        vectors++;
        if ({wa, wd, ra, rb} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: wr_addr=%h wdata=%h rd_a=%h rd_b=%h required 0", wa, wd, ra, rb);
        end
        vectors++;
        if ({s_busy, s_done, s_we, s_rd_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_small: busy/done/we/rd_en=%b required 0000",
                     {s_busy, s_done, s_we, s_rd_en});
        end
        #2 rst = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pointwise_ones();
        int s;
        logic [AW-1:0] ea;
        for (int i = 0; i < 512; i++) mem[i] = 32'd65536;
        clear_mon();
        start_big(1'b0, 32'd0, 10'd0, 10'd256, 10'd512, s);
        wait_big(1, N + 40);
        vectors++;
        if (w_data_q.size() !== N) begin
            miscompares++;
            $display("FAIL ones_count: writes=%0d required %0d", w_data_q.size(), N);
        end
        for (int i = 0; i < N && i < w_data_q.size(); i++) begin
            ea = 10'd512 + AW'(i);
            vectors++;
            if (w_data_q[i] !== 32'd1 || w_addr_q[i] !== ea || w_cyc_q[i] - s !== 4 + i) begin
                miscompares++;
                $display("FAIL ones_write[%0d]: addr=%h data=%h cyc=%0d required addr=%h data=1 cyc=%0d",
                         i, w_addr_q[i], w_data_q[i], w_cyc_q[i] - s, ea, 4 + i);
            end
        end
        vectors++;
        if (done_q.size() !== 1 || done_q[0] - s !== 260) begin
            miscompares++;
            $display("FAIL ones_done: pulses=%0d first_cyc=%0d required 1 pulse at 260",
                     done_q.size(), done_q.size() > 0 ? done_q[0] - s : -1);
        end
    endtask

    task automatic test_boundary();
        int s;
        logic [AW-1:0] ea;
        longint rr, p3;
        for (int i = 100; i < 356; i++) mem[i] = rand_coef();
        for (int i = 700; i < 956; i++) mem[i] = rand_coef();
        mem[100] = Q;          mem[700] = 32'd1;
        mem[101] = -65536;     mem[701] = 32'd65536;
        mem[102] = 32'd0;
        mem[103] = Q - 1;      mem[703] = Q - 1;
        exp_q.delete();
        build_exp(1'b0, 32'd0, 10'd100, 10'd700);
        clear_mon();
        start_big(1'b0, 32'd0, 10'd100, 10'd700, 10'd400, s);
        wait_big(1, N + 40);
        vectors++;
        if (w_data_q.size() !== N) begin
            miscompares++;
            $display("FAIL bnd_count: writes=%0d required %0d", w_data_q.size(), N);
        end
        for (int i = 0; i < N && i < w_data_q.size(); i++) begin
            ea = 10'd400 + AW'(i);
            vectors++;
            if (w_data_q[i] !== exp_q[i] || w_addr_q[i] !== ea || w_cyc_q[i] - s !== 4 + i) begin
                miscompares++;
                $display("FAIL bnd_write[%0d]: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                         i, w_addr_q[i], w_data_q[i], w_cyc_q[i] - s, ea, exp_q[i], 4 + i);
            end
        end
        if (w_data_q.size() >= 4) begin
            vectors++;
            if (w_data_q[0] !== 32'd0 || w_data_q[1] !== 32'hFFFF_FFFF || w_data_q[2] !== 32'd0) begin
                miscompares++;
                $display("FAIL bnd_known: got %h %h %h required 00000000 ffffffff 00000000",
                         w_data_q[0], w_data_q[1], w_data_q[2]);
            end
            rr = longint'($signed(w_data_q[3]));
            p3 = longint'(Q - 1) * longint'(Q - 1);
            vectors++;
            if ((rr * 64'sd4294967296 - p3) % Q != 0 || rr <= -Q || rr >= Q) begin
                miscompares++;
                $display("FAIL bnd_qm1sq: result %0d not congruent to (Q-1)^2*2^-32 within (-Q,Q)", rr);
            end
        end
    endtask

    task automatic test_scale();
        int s;
        logic [AW-1:0] ea;
        longint rr;
        for (int i = 0; i < 256; i++) mem[i] = i;
        for (int i = 256; i < 512; i++) mem[i] = $urandom;
        exp_q.delete();
        build_exp(1'b1, 32'd4193792, 10'd0, 10'd256);
        clear_mon();
        start_big(1'b1, 32'd4193792, 10'd0, 10'd256, 10'd512, s);
        wait_big(1, N + 40);
        vectors++;
        if (w_data_q.size() !== N) begin
            miscompares++;
            $display("FAIL scale_count: writes=%0d required %0d", w_data_q.size(), N);
        end
        for (int i = 0; i < N && i < w_data_q.size(); i++) begin
            ea = 10'd512 + AW'(i);
            rr = longint'($signed(w_data_q[i]));
            vectors++;
            if (w_data_q[i] !== exp_q[i] || (rr - i) % Q != 0 || rr <= -Q || rr >= Q ||
                w_addr_q[i] !== ea) begin
                miscompares++;
                $display("FAIL scale_write[%0d]: addr=%h data=%0d required addr=%h data=%0d (== i mod Q)",
                         i, w_addr_q[i], rr, ea, $signed(exp_q[i]));
            end
        end
    endtask

    task automatic test_inplace_random();
        int s;
        logic [AW-1:0] ea;
        for (int i = 0; i < 1024; i++) mem[i] = rand_coef();
        exp_q.delete();
        build_exp(1'b0, 32'd0, 10'd900, 10'd300);
        clear_mon();
        start_big(1'b0, 32'd0, 10'd900, 10'd300, 10'd900, s);
        wait_big(1, N + 40);
        vectors++;
        if (w_data_q.size() !== N) begin
            miscompares++;
            $display("FAIL inplace_count: writes=%0d required %0d", w_data_q.size(), N);
        end
        for (int i = 0; i < N && i < w_data_q.size(); i++) begin
            ea = 10'd900 + AW'(i);
            vectors++;
            if (w_data_q[i] !== exp_q[i] || w_addr_q[i] !== ea || mem[ea] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL inplace_write[%0d]: addr=%h data=%h mem=%h required addr=%h data=%h",
                         i, w_addr_q[i], w_data_q[i], mem[ea], ea, exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap_ignore();
        int s;
        bit seen;
        logic [SAW-1:0] ai, bi;
        logic [SAW-1:0] wrap_addr [SN];
        wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 256; i++) smem[i] = rand_coef();
        exp_q.delete();
        for (int i = 0; i < SN; i++) begin
            ai = 8'h10 + SAW'(i);
            bi = 8'h20 + SAW'(i);
            exp_q.push_back(mont_ref(smem[ai], smem[bi]));
        end
        s_addr_q.delete(); s_data_q.delete(); s_cyc_q.delete(); s_done_q.delete();
        @(negedge clk);
        s_start = 1'b1; s_mode = 1'b0; s_cval = $urandom; s_ba = 8'h10; s_bb = 8'h20; s_bd = 8'hFE;
        s = ncyc;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        s_start = 1'b1; s_mode = 1'b1; s_ba = 8'h80; s_bb = 8'h90; s_bd = 8'h40;
        @(negedge clk);
        s_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (s_done_q.size() != 0) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (!seen || s_data_q.size() !== SN) begin
            miscompares++;
            $display("FAIL wrap_count: done_seen=%0d writes=%0d required 1 and %0d", seen, s_data_q.size(), SN);
        end
        for (int i = 0; i < SN && i < s_data_q.size(); i++) begin
            vectors++;
            if (s_addr_q[i] !== wrap_addr[i] || s_data_q[i] !== exp_q[i] || s_cyc_q[i] - s !== 4 + i) begin
                miscompares++;
                $display("FAIL wrap_write[%0d]: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                         i, s_addr_q[i], s_data_q[i], s_cyc_q[i] - s, wrap_addr[i], exp_q[i], 4 + i);
            end
        end
        vectors++;
        if (s_done_q.size() !== 1 || s_done_q[0] - s !== SN + 4) begin
            miscompares++;
            $display("FAIL wrap_done: pulses=%0d first_cyc=%0d required 1 pulse at %0d",
                     s_done_q.size(), s_done_q.size() > 0 ? s_done_q[0] - s : -1, SN + 4);
        end
    endtask

    task automatic test_reset_mid_run();
        int s, n0;
        logic [AW-1:0] ea;
        for (int i = 0; i < 512; i++) mem[i] = rand_coef();
        clear_mon();
        start_big(1'b0, 32'd0, 10'd0, 10'd256, 10'd512, s);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1;
        n0 = w_data_q.size();
        vectors++;
        if ({busy, we, rd_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL midrst_outputs: busy/we/rd_en=%b required 000", {busy, we, rd_en});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (w_data_q.size() !== n0 || busy !== 1'b0 || done_q.size() !== 0) begin
            miscompares++;
            $display("FAIL midrst_quiet: writes=%0d busy=%b done_pulses=%0d required writes=%0d busy=0 done=0",
                     w_data_q.size(), busy, done_q.size(), n0);
        end
        for (int i = 0; i < 512; i++) mem[i] = rand_coef();
        exp_q.delete();
        build_exp(1'b0, 32'd0, 10'd0, 10'd256);
        clear_mon();
        start_big(1'b0, 32'd0, 10'd0, 10'd256, 10'd512, s);
        wait_big(1, N + 40);
        vectors++;
        if (w_data_q.size() !== N || done_q.size() !== 1 || done_q[0] - s !== N + 4) begin
            miscompares++;
            $display("FAIL midrst_rerun: writes=%0d done_pulses=%0d required %0d writes and 1 done at %0d",
                     w_data_q.size(), done_q.size(), N, N + 4);
        end
        for (int i = 0; i < N && i < w_data_q.size(); i++) begin
            ea = 10'd512 + AW'(i);
            vectors++;
            if (w_data_q[i] !== exp_q[i] || w_addr_q[i] !== ea || w_cyc_q[i] - s !== 4 + i) begin
                miscompares++;
                $display("FAIL midrst_write[%0d]: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                         i, w_addr_q[i], w_data_q[i], w_cyc_q[i] - s, ea, exp_q[i], 4 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s1, s2, ecyc;
        logic [AW-1:0] ea;
        logic [31:0] c2;
        for (int i = 0; i < 512; i++) mem[i] = rand_coef();
        c2 = rand_coef();
        exp_q.delete();
        build_exp(1'b0, 32'd0, 10'd0, 10'd256);
        build_exp(1'b1, c2, 10'd256, 10'd0);
        clear_mon();
        start_big(1'b0, 32'd0, 10'd0, 10'd256, 10'd512, s1);
        repeat (N + 3) @(negedge clk);
        start_big(1'b1, c2, 10'd256, 10'd0, 10'd768, s2);
        wait_big(2, N + 40);
        vectors++;
        if (w_data_q.size() !== 2 * N || done_q.size() !== 2) begin
            miscompares++;
            $display("FAIL b2b_count: writes=%0d done_pulses=%0d required %0d and 2",
                     w_data_q.size(), done_q.size(), 2 * N);
        end
        for (int i = 0; i < 2 * N && i < w_data_q.size(); i++) begin
            ea   = (i < N) ? 10'd512 + AW'(i) : 10'd768 + AW'(i - N);
            ecyc = (i < N) ? s1 + 4 + i : s2 + 4 + (i - N);
            vectors++;
            if (w_data_q[i] !== exp_q[i] || w_addr_q[i] !== ea || w_cyc_q[i] !== ecyc) begin
                miscompares++;
                $display("FAIL b2b_write[%0d]: addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                         i, w_addr_q[i], w_data_q[i], w_cyc_q[i], ea, exp_q[i], ecyc);
            end
        end
        if (done_q.size() == 2) begin
            vectors++;
            if (done_q[0] - s1 !== N + 4 || done_q[1] - s2 !== N + 4) begin
                miscompares++;
                $display("FAIL b2b_done: done at %0d and %0d required %0d and %0d",
                         done_q[0] - s1, done_q[1] - s2, N + 4, N + 4);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; cval = '0; ba = '0; bb = '0; bd = '0;
        s_start = 1'b0; s_mode = 1'b0; s_cval = '0; s_ba = '0; s_bb = '0; s_bd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_pointwise_ones();
        test_boundary();
        test_scale();
        test_inplace_random();
        test_wrap_ignore();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mont_pwm_ctrl.md
Name: mont_pwm_ctrl

Overview:
- Sequencer for the Montgomery-reduction datapath in the NTT/polynomial arithmetic path (Dilithium, Q = 8380417).
- On a start pulse it streams N coefficient pairs out of synchronous-read memory and multiplies each pair to a 64-bit product.
- Each product is Montgomery-reduced to a signed 32-bit value and written back to a destination region.
- Two modes: pointwise a*b between two polynomials, or scaling of polynomial a by a constant (to/from Montgomery domain).

Parameters:
Q, 8380417, modulus
QINV, 58728449, Q^-1 mod 2^32
N, 256, coefficients per polynomial
AW, 10, memory address width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  start request, sampled only in IDLE
mode_i  in  1  0 = pointwise a*b, 1 = a*const_i; latched at start
const_i  in  32  signed scaling constant; latched at start
src_a_base_i  in  AW  base address of polynomial a; latched at start
src_b_base_i  in  AW  base address of polynomial b; latched at start
dst_base_i  in  AW  base address of result; latched at start
rd_en_o  out  1  read strobe, both ports
rd_addr_a_o  out  AW  read address, port A
rd_addr_b_o  out  AW  read address, port B
rdata_a_i  in  32  signed data, port A, valid 1 cycle after rd_en_o
rdata_b_i  in  32  signed data, port B, valid 1 cycle after rd_en_o
we_o  out  1  write strobe
wr_addr_o  out  AW  write address
wdata_o  out  32  signed reduced result
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): FSM goes to IDLE; all outputs are 0; counters, latched config and pipeline valid bits are cleared. An in-flight operation is abandoned and issues no further writes.
- FSM states: IDLE -> RUN on start_i=1. RUN -> DRAIN after issuing index N-1. DRAIN -> DONE when the pipeline is empty. DONE -> IDLE unconditionally.
- busy_o = 1 in RUN and DRAIN. done_o = 1 only in DONE. start_i is ignored in RUN, DRAIN and DONE.
- Start timing: start_i sampled at cycle 0. Config is latched at the same edge. RUN begins at cycle 1.
- RUN, cycle 1+i for i = 0..N-1:
  - rd_en_o = 1, rd_addr_a_o = src_a_base + i, rd_addr_b_o = src_b_base + i.
  - Addresses wrap modulo 2^AW.
  - In mode 1, port B addresses are still driven but rdata_b_i is ignored.
- Stage 2 (cycle after read):
  - operand b = rdata_b_i (mode 0) or latched const (mode 1).
  - p = signed(a) * signed(b), full 64-bit, registered.
- Stage 3:
  - t = low 32 bits of (p * QINV), interpreted as signed.
  - r = (p - t*Q) arithmetic-shifted right by 32.
  - wdata = r[31:0], registered. No +Q correction: r lies in (-Q, Q) for |p| < Q*2^31.
- Write timing: we_o = 1 at cycle 4+i with wr_addr_o = dst_base + i (mod 2^AW).
- Write ordering: exactly N writes, strictly in index order, one per cycle, no gaps.
- Completion: last write at cycle N+3, DONE (done_o = 1) at cycle N+4, IDLE at N+5. A start_i at N+5 is accepted.
- Outputs when idle: we_o, rd_en_o = 0 outside active stages. Address and data outputs may hold their last values.
- Overlapping regions: dst may equal a source region. Each write of index i occurs after the read of index i, so in-place operation is correct.

Test Plan:
- Reset: rst_i pulse with clock stopped -> busy_o, done_o, we_o, rd_en_o all 0 immediately.
- Pointwise, N=256: a[i] = b[i] = 65536 (p = 2^32) -> all 256 writes wdata = 1, first we_o at cycle 4, done_o at cycle 260 exactly once.
- Boundary values: a = Q, b = 1 -> 0; a = -65536, b = 65536 -> 0xFFFFFFFF (-1); a = 0 -> 0; a = b = Q-1 -> result congruent to (Q-1)^2 * 2^-32 mod Q and within (-Q, Q).
- Scale mode: const_i = 4193792 (2^32 mod Q), a[i] = i, b memory holding garbage -> wdata ≡ i (mod Q) and within (-Q, Q) for all i; port B data has no effect.
- Wrap and ignore, AW=8, N=4, dst_base = 0xFE: writes go to 0xFE, 0xFF, 0x00, 0x01. A start_i pulse during RUN does not change latched bases or produce extra writes.
- Reset mid-run: assert rst_i at cycle 50 -> no we_o afterwards, busy_o = 0. A new start then completes a full N-write sequence.
